// File: rtl/des_round_engine.sv
// DES 16-round iterative core: one Feistel round per clock on the L/R registers.
// Latency: start in cycle 0 -> done pulse with dout valid in cycle 17 (16 round cycles).
// Backpressure: none; start is accepted only in IDLE or DONE and is ignored while busy.

// One DES S-box as a 64-entry nibble table, entry (row*16+col) stored MSB-first.
module des_sbox #(
  parameter logic [255:0] TABLE = 256'h0
) (
  input  logic [5:0] six,
  output logic [3:0] nib
);

  logic [7:0]   shamt;
  logic [255:0] shifted;

  // Row is {b5,b0}, column is b4:1; shift the selected nibble up to the top.
  always_comb begin
    shamt   = {six[5], six[0], six[4:1], 2'b00};
    shifted = TABLE << shamt;
    nib     = shifted[255:252];
  end

endmodule

module des_round_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] din,
  input  logic [47:0] subkey,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done,
  output logic [63:0] dout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [255:0] S1_TBL = {
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
    64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D};
  localparam logic [255:0] S2_TBL = {
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
    64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9};
  localparam logic [255:0] S3_TBL = {
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
    64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C};
  localparam logic [255:0] S4_TBL = {
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
    64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E};
  localparam logic [255:0] S5_TBL = {
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
    64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453};
  localparam logic [255:0] S6_TBL = {
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
    64'h9EF528C3704A1DB6, 64'h432C95FABE17608D};
  localparam logic [255:0] S7_TBL = {
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
    64'h14BDC37EAF680592, 64'h6BD814A7950FE23C};
  localparam logic [255:0] S8_TBL = {
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
    64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

  state_t      state_q, state_d;
  logic [31:0] l_q, l_d;
  logic [31:0] r_q, r_d;
  logic [3:0]  round_q, round_d;
  logic [63:0] dout_q, dout_d;

  logic [47:0] r_exp;
  logic [47:0] key_mix;
  logic [31:0] s_out;
  logic [31:0] f_out;
  logic [31:0] r_next;

  // E-expansion of R, mixed with the externally supplied round subkey.
  always_comb begin
    r_exp = {r_q[0],    r_q[31:27],
             r_q[28:23], r_q[24:19],
             r_q[20:15], r_q[16:11],
             r_q[12:7],  r_q[8:3],
             r_q[4:0],   r_q[31]};
    key_mix = r_exp ^ subkey;
  end

  des_sbox #(.TABLE(S1_TBL)) sbox1 (.six(key_mix[47:42]), .nib(s_out[31:28]));
  des_sbox #(.TABLE(S2_TBL)) sbox2 (.six(key_mix[41:36]), .nib(s_out[27:24]));
  des_sbox #(.TABLE(S3_TBL)) sbox3 (.six(key_mix[35:30]), .nib(s_out[23:20]));
  des_sbox #(.TABLE(S4_TBL)) sbox4 (.six(key_mix[29:24]), .nib(s_out[19:16]));
  des_sbox #(.TABLE(S5_TBL)) sbox5 (.six(key_mix[23:18]), .nib(s_out[15:12]));
  des_sbox #(.TABLE(S6_TBL)) sbox6 (.six(key_mix[17:12]), .nib(s_out[11:8]));
  des_sbox #(.TABLE(S7_TBL)) sbox7 (.six(key_mix[11:6]),  .nib(s_out[7:4]));
  des_sbox #(.TABLE(S8_TBL)) sbox8 (.six(key_mix[5:0]),   .nib(s_out[3:0]));

  // P permutation of the S-box output, then the Feistel XOR into the new R.
  always_comb begin
    f_out = {s_out[16], s_out[25], s_out[12], s_out[11],
             s_out[3],  s_out[20], s_out[4],  s_out[15],
             s_out[31], s_out[17], s_out[9],  s_out[6],
             s_out[27], s_out[14], s_out[1],  s_out[22],
             s_out[30], s_out[24], s_out[8],  s_out[18],
             s_out[0],  s_out[5],  s_out[29], s_out[23],
             s_out[13], s_out[19], s_out[2],  s_out[26],
             s_out[10], s_out[21], s_out[28], s_out[7]};
    r_next = l_q ^ f_out;
  end

  // Control FSM and datapath next-state; every register holds unless updated.
  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    round_d = round_q;
    dout_d  = dout_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          l_d     = din[63:32];
          r_d     = din[31:0];
          round_d = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        l_d     = r_q;
        r_d     = r_next;
        round_d = round_q + 4'd1;
        if (round_q == 4'd15) begin
          state_d = ST_DONE;
          // Swap undone here: output is {R16, L16}.
          dout_d  = {r_next, r_q};
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset taking priority over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      l_q     <= 32'd0;
      r_q     <= 32'd0;
      round_q <= 4'd0;
      dout_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      round_q <= round_d;
      dout_q  <= dout_d;
    end
  end

  // Status outputs decode directly from the registered state.
  always_comb begin
    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_DONE);
    round_idx = round_q;
    dout      = dout_q;
  end

endmodule

// File: tb/tb_des_round_engine.sv
module tb_des_round_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] din;
  logic [47:0] subkey;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;
  logic [63:0] dout;

  logic [47:0] keys [16];
  int compared;
  int mismatched;

  // Standard DES tables, 1-indexed from the MSB as published.
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // Subkeys K1..K16 for key 133457799BBCDFF1.
  localparam logic [47:0] FIPS_K [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

  localparam logic [63:0] FIPS_IN  = 64'hCC00CCFF_F0AAF0AA;
  localparam logic [63:0] FIPS_OUT = 64'h0A4CD995_43423234;

  des_round_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .din       (din),
    .subkey    (subkey),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done),
    .dout      (dout)
  );

  // External key schedule stand-in: subkey follows round_idx combinationally.
  assign subkey = keys[round_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // busy and done must never be high together.
  always @(negedge clk) begin
    compared++;
    if (busy === 1'b1 && done === 1'b1) begin
      mismatched++;
      $display("FAIL busy_done_excl: busy=%b done=%b required not both 1", busy, done);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference round function straight from the published tables.
  function automatic logic [31:0] ref_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e, x, t;
    logic [31:0] s, p, bv;
    logic [5:0]  six, ei, ci;
    logic [4:0]  pi;
    logic [2:0]  bi;
    int          sval;
    e = '0;
    for (int i = 0; i < 48; i++) begin
      ei = 6'(i);
      bv = r >> (32 - E_T[ei]);
      e  = {e[46:0], bv[0]};
    end
    x = e ^ k;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      bi   = 3'(b);
      t    = x >> (42 - 6 * b);
      six  = t[5:0];
      ci   = {six[5], six[0], six[4:1]};
      sval = SB[bi][ci];
      s    = {s[27:0], sval[3:0]};
    end
    p = '0;
    for (int i = 0; i < 32; i++) begin
      pi = 5'(i);
      bv = s >> (32 - P_T[pi]);
      p  = {p[30:0], bv[0]};
    end
    return p;
  endfunction

  // Sixteen Feistel rounds with the current key table; returns {R16, L16}.
  function automatic logic [63:0] ref_des(input logic [63:0] d);
    logic [31:0] l, r, t;
    l = d[63:32];
    r = d[31:0];
    for (int n = 0; n < 16; n++) begin
      t = r;
      r = l ^ ref_f(r, keys[4'(n)]);
      l = t;
    end
    return {r, l};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; returns positioned in cycle 1 of the operation.
  task automatic start_op(input logic [63:0] d);
    start = 1'b1;
    din   = d;
    tick();
    start = 1'b0;
    din   = {$urandom(), $urandom()};
  endtask

  // From cycle 1, advance until done or a budget runs out; lat is done's cycle number.
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic load_fips();
    for (int i = 0; i < 16; i++) keys[4'(i)] = FIPS_K[4'(i)];
  endtask

  task automatic load_random();
    for (int i = 0; i < 16; i++) keys[4'(i)] = 48'({$urandom(), $urandom()});
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; din = FIPS_IN;
    tick(); tick();
    compared += 4;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b required 0", done); end
    if (round_idx !== 4'd0) begin mismatched++; $display("FAIL reset_round: got %0d required 0", round_idx); end
    if (dout !== 64'd0) begin mismatched++; $display("FAIL reset_dout: got %h required 0", dout); end
    rst = 1'b0; start = 1'b0;
    tick();
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL start_with_rst: busy=%b required 0", busy); end
  endtask

  task automatic test_fips();
    load_fips();
    start_op(FIPS_IN);
    for (int c = 1; c <= 16; c++) begin
      compared += 3;
      if (busy !== 1'b1) begin mismatched++; $display("FAIL fips_busy c%0d: got %b required 1", c, busy); end
      if (done !== 1'b0) begin mismatched++; $display("FAIL fips_done c%0d: got %b required 0", c, done); end
      if (round_idx !== 4'(c - 1)) begin
        mismatched++; $display("FAIL fips_round c%0d: got %0d required %0d", c, round_idx, c - 1);
      end
      if (c == 2) begin
        compared += 2;
        if (dut.l_q !== 32'hF0AAF0AA) begin mismatched++; $display("FAIL fips_L1: got %h required F0AAF0AA", dut.l_q); end
        if (dut.r_q !== 32'hEF4A6544) begin mismatched++; $display("FAIL fips_R1: got %h required EF4A6544", dut.r_q); end
      end
      tick();
    end
    compared += 4;
    if (done !== 1'b1) begin mismatched++; $display("FAIL fips_done17: got %b required 1", done); end
    if (busy !== 1'b0) begin mismatched++; $display("FAIL fips_busy17: got %b required 0", busy); end
    if (round_idx !== 4'd0) begin mismatched++; $display("FAIL fips_round17: got %0d required 0", round_idx); end
    if (dout !== FIPS_OUT) begin mismatched++; $display("FAIL fips_dout: got %h required %h", dout, FIPS_OUT); end
    tick();
    compared += 2;
    if (done !== 1'b0) begin mismatched++; $display("FAIL fips_done_pulse: got %b required 0", done); end
    if (dout !== FIPS_OUT) begin mismatched++; $display("FAIL fips_dout_hold: got %h required %h", dout, FIPS_OUT); end
  endtask

  // IP(ciphertext) is the encryption pre-output, and decrypting it yields IP(plaintext).
  task automatic test_decrypt();
    int lat;
    logic [63:0] exp_d;
    for (int i = 0; i < 16; i++) keys[4'(i)] = FIPS_K[4'(15 - i)];
    exp_d = ref_des(FIPS_OUT);
    start_op(FIPS_OUT);
    wait_done(lat);
    compared += 3;
    if (lat !== 17) begin mismatched++; $display("FAIL dec_latency: got %0d required 17", lat); end
    if (dout !== FIPS_IN) begin mismatched++; $display("FAIL dec_dout: got %h required %h", dout, FIPS_IN); end
    if (dout !== exp_d) begin mismatched++; $display("FAIL dec_model: got %h required %h", dout, exp_d); end
    tick();
  endtask

  task automatic test_ignored_start();
    load_fips();
    start_op(FIPS_IN);
    for (int c = 1; c <= 16; c++) begin
      compared += 2;
      if (done !== 1'b0) begin mismatched++; $display("FAIL ign_done c%0d: got %b required 0", c, done); end
      if (round_idx !== 4'(c - 1)) begin
        mismatched++; $display("FAIL ign_round c%0d: got %0d required %0d", c, round_idx, c - 1);
      end
      if (c == 5 || c == 10) begin
        start = 1'b1;
        din   = {$urandom(), $urandom()};
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    compared += 2;
    if (done !== 1'b1) begin mismatched++; $display("FAIL ign_done17: got %b required 1", done); end
    if (dout !== FIPS_OUT) begin mismatched++; $display("FAIL ign_dout: got %h required %h", dout, FIPS_OUT); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [63:0] din_a, din_b, exp_a, exp_b;
    load_random();
    din_a = {$urandom(), $urandom()};
    exp_a = ref_des(din_a);
    start_op(din_a);
    wait_done(lat);
    compared += 2;
    if (lat !== 17) begin mismatched++; $display("FAIL b2b_lat_a: got %0d required 17", lat); end
    if (dout !== exp_a) begin mismatched++; $display("FAIL b2b_dout_a: got %h required %h", dout, exp_a); end
    // New keys and data launched from the DONE cycle itself.
    load_random();
    din_b = {$urandom(), $urandom()};
    exp_b = ref_des(din_b);
    start_op(din_b);
    for (int c = 1; c <= 16; c++) begin
      compared += 3;
      if (busy !== 1'b1) begin mismatched++; $display("FAIL b2b_busy c%0d: got %b required 1", c, busy); end
      if (done !== 1'b0) begin mismatched++; $display("FAIL b2b_done c%0d: got %b required 0", c, done); end
      if (dout !== exp_a) begin mismatched++; $display("FAIL b2b_hold c%0d: got %h required %h", c, dout, exp_a); end
      tick();
    end
    compared += 2;
    if (done !== 1'b1) begin mismatched++; $display("FAIL b2b_done17: got %b required 1", done); end
    if (dout !== exp_b) begin mismatched++; $display("FAIL b2b_dout_b: got %h required %h", dout, exp_b); end
    for (int c = 0; c < 4; c++) tick();
    compared += 2;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL b2b_idle_busy: got %b required 0", busy); end
    if (dout !== exp_b) begin mismatched++; $display("FAIL b2b_idle_hold: got %h required %h", dout, exp_b); end
  endtask

  task automatic test_rst_mid_run();
    int lat;
    int stray;
    logic [63:0] d, exp_d;
    load_random();
    start_op({$urandom(), $urandom()});
    for (int c = 1; c < 8; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    compared += 4;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL mrst_busy: got %b required 0", busy); end
    if (done !== 1'b0) begin mismatched++; $display("FAIL mrst_done: got %b required 0", done); end
    if (round_idx !== 4'd0) begin mismatched++; $display("FAIL mrst_round: got %0d required 0", round_idx); end
    if (dout !== 64'd0) begin mismatched++; $display("FAIL mrst_dout: got %h required 0", dout); end
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1 || busy === 1'b1) stray++;
      tick();
    end
    compared++;
    if (stray !== 0) begin mismatched++; $display("FAIL mrst_no_done: got %0d active cycles required 0", stray); end
    d = {$urandom(), $urandom()};
    exp_d = ref_des(d);
    start_op(d);
    wait_done(lat);
    compared += 2;
    if (lat !== 17) begin mismatched++; $display("FAIL mrst_lat: got %0d required 17", lat); end
    if (dout !== exp_d) begin mismatched++; $display("FAIL mrst_dout2: got %h required %h", dout, exp_d); end
    tick();
  endtask

  task automatic test_random();
    int lat;
    logic [63:0] d, exp_d;
    for (int n = 0; n < 8; n++) begin
      load_random();
      d = {$urandom(), $urandom()};
      exp_d = ref_des(d);
      start_op(d);
      wait_done(lat);
      compared += 2;
      if (lat !== 17) begin mismatched++; $display("FAIL rand_lat n%0d: got %0d required 17", n, lat); end
      if (dout !== exp_d) begin mismatched++; $display("FAIL rand_dout n%0d: got %h required %h", n, dout, exp_d); end
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      tick();
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst   = 1'b1;
    start = 1'b0;
    din   = 64'd0;
    for (int i = 0; i < 16; i++) keys[4'(i)] = 48'd0;
    test_reset();
    test_fips();
    test_decrypt();
    test_ignored_start();
    test_back_to_back();
    test_rst_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
